// File: rtl/core_scoreboard.sv
// Register-write scoreboard: per-register count of in-flight writers, used to
// stall decode on RAW hazards and on per-register counter saturation.
module core_scoreboard #(
   parameter int unsigned NREGS  = 32,
   parameter int unsigned RIDX_W = 5,
   parameter int unsigned CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d_valid,
   input  logic              d_flush,
   input  logic [RIDX_W-1:0] d_rs1,
   input  logic [RIDX_W-1:0] d_rs2,
   input  logic [RIDX_W-1:0] d_rd,
   input  logic              d_reg_wen,
   output logic              d_stall,
   input  logic              w_valid,
   input  logic              w_reg_wen,
   input  logic [RIDX_W-1:0] w_rd,
   input  logic              kill_x_valid,
   input  logic [RIDX_W-1:0] kill_x_rd,
   input  logic              kill_m_valid,
   input  logic [RIDX_W-1:0] kill_m_rd,
   output logic              busy,
   output logic              err
);

   localparam int unsigned      SUM_W   = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] cnt_d [NREGS];
   logic [NREGS-1:0] wb_dec;
   logic [NREGS-1:0] inc;
   logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
   logic             hz_rs1, hz_rs2, sat, issue;
   logic [SUM_W-1:0] up, dec_n;
   logic             busy_q, busy_d, err_q, err_d;

   // Per-register writeback retire strobes; register 0 is never tracked.
   always_comb begin
      wb_dec = '0;
      for (int r = 1; r < NREGS; r++) begin
         wb_dec[r] = w_valid & w_reg_wen & (w_rd == RIDX_W'(r));
      end
   end

   // Hazard and saturation detection; a last write retiring now is forwarded from W.
   always_comb begin
      cnt_rs1 = cnt_q[d_rs1];
      cnt_rs2 = cnt_q[d_rs2];
      cnt_rd  = cnt_q[d_rd];
      hz_rs1  = (d_rs1 != '0) && (cnt_rs1 != '0)
                && !((cnt_rs1 == CNT_W'(1)) && wb_dec[d_rs1]);
      hz_rs2  = (d_rs2 != '0) && (cnt_rs2 != '0)
                && !((cnt_rs2 == CNT_W'(1)) && wb_dec[d_rs2]);
      sat     = d_reg_wen && (d_rd != '0) && (cnt_rd == CNT_MAX) && !wb_dec[d_rd];
      d_stall = (hz_rs1 | hz_rs2 | sat) & d_valid & ~d_flush;
      issue   = d_valid & ~d_flush & ~d_stall & d_reg_wen;
      inc     = '0;
      for (int r = 1; r < NREGS; r++) begin
         inc[r] = issue & (d_rd == RIDX_W'(r));
      end
   end

   // Counter next state: net inc/dec at widened width, clamp and flag on under/overflow.
   always_comb begin
      err_d    = err_q;
      busy_d   = 1'b0;
      up       = '0;
      dec_n    = '0;
      cnt_d[0] = '0;
      for (int r = 1; r < NREGS; r++) begin
         up    = SUM_W'(cnt_q[r]) + SUM_W'(inc[r]);
         dec_n = SUM_W'(wb_dec[r])
                 + SUM_W'(kill_x_valid && (kill_x_rd == RIDX_W'(r)))
                 + SUM_W'(kill_m_valid && (kill_m_rd == RIDX_W'(r)));
         cnt_d[r] = cnt_q[r];
         if (up < dec_n) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else if ((up - dec_n) > SUM_W'(CNT_MAX)) begin
            err_d = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(up - dec_n);
         end
         busy_d = busy_d | (cnt_d[r] != '0);
      end
   end

   // State registers with synchronous reset; reset drops all outstanding writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy = busy_q;
   assign err  = err_q;

endmodule
